segment_cache_ctrl: RTL

- Captures the CPU's live LCD drive outputs into a shadow cache on every CPU LCD update strobe.
- Commits the shadow to the display caches once per frame, on the vblank rising edge, so the video segment lookup never tears mid-frame.
- Blanks the display when the CPU turns the LCD off or stops strobing for a set number of frames.
- Sits between the CPU core and the video segment renderer. It covers both SM510-family (a/b/bs, H-strobed) and SM5a (W'/W) layouts.

---
 rtl/segment_cache_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/segment_cache_ctrl.sv
// segment_cache_ctrl: captures CPU LCD drive outputs into a shadow on each
// lcd_strobe and commits the shadow to the display caches once per frame,
// one cycle after the vblank rising edge, so the renderer never sees tearing.
// Caches are blanked while the LCD is off or after STALE_FRAMES frames
// without any strobe.
//
// Optional build macro: SEGMENT_ACCUM_EN -- shadow writes OR into the existing
// bits and the shadow is cleared in the commit cycle (lit-at-any-strobe).
// Without it the last write wins and the shadow persists across frames.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   cpu_id                    4 = SM5a, anything else = SM510 family
//   lcd_strobe                CPU LCD outputs valid this cycle
//   lcd_h, lcd_a, lcd_b, lcd_bs   SM510 row select and segment data
//   lcd_off                   CPU LCD-off flag
//   cpu_w_prime, cpu_w_main   SM5a W'/W registers (9 x 4 bits)
//   vblank_int                video vertical blank
//   cache_*                   committed caches seen by the renderer
//   commit_pulse              high in the cycle the caches update
//   display_stale             high while the watchdog holds caches cleared
module segment_cache_ctrl #(
  parameter int unsigned STALE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       cpu_id,
  input  logic             lcd_strobe,
  input  logic [3:0]       lcd_h,
  input  logic [15:0]      lcd_a,
  input  logic [15:0]      lcd_b,
  input  logic             lcd_bs,
  input  logic             lcd_off,
  input  logic [8:0][3:0]  cpu_w_prime,
  input  logic [8:0][3:0]  cpu_w_main,
  input  logic             vblank_int,
  output logic [3:0][15:0] cache_segment_a,
  output logic [3:0][15:0] cache_segment_b,
  output logic [1:0]       cache_segment_bs,
  output logic [8:0][3:0]  cache_w_prime,
  output logic [8:0][3:0]  cache_w_main,
  output logic             commit_pulse,
  output logic             display_stale
);

  localparam int unsigned ROWS    = 4;
  localparam int unsigned BS_ROWS = 2;
  localparam int unsigned CNT_W   = 4;
  localparam logic [3:0]  SM5A_ID = 4'd4;
  localparam logic [CNT_W-1:0] STALE_CNT = CNT_W'(STALE_FRAMES);

`ifdef SEGMENT_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  typedef enum logic [1:0] {ST_WAIT, ST_RUN, ST_COMMIT} state_t;

  state_t state, state_d;
  logic   vblank_q;
  logic   vblank_edge_c;
  logic   commit_c;

  logic [3:0][15:0] sh_a, sh_a_d, sh_b, sh_b_d;
  logic [1:0]       sh_bs, sh_bs_d;
  logic [8:0][3:0]  sh_wp, sh_wp_d, sh_wm, sh_wm_d;

  logic             strobe_seen, strobe_seen_d;
  logic [CNT_W-1:0] stale_cnt, stale_cnt_d;
  logic             stale_next_c;
  logic             blank_c;

  assign vblank_edge_c = vblank_int & ~vblank_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_WAIT;
    else          state <= state_d;
  end

  // Next-state: WAIT and RUN both commit on the vblank edge; COMMIT lasts one cycle
  always_comb begin
    state_d  = state;
    commit_c = 1'b0;
    case (state)
      ST_WAIT:   if (vblank_edge_c) state_d = ST_COMMIT;
      ST_RUN:    if (vblank_edge_c) state_d = ST_COMMIT;
      ST_COMMIT: begin
        commit_c = 1'b1;
        state_d  = ST_RUN;
      end
      default:   state_d = ST_WAIT;
    endcase
  end

  // Shadow capture; in accumulate mode the commit-cycle clear precedes any same-cycle strobe
  always_comb begin
    sh_a_d  = sh_a;
    sh_b_d  = sh_b;
    sh_bs_d = sh_bs;
    sh_wp_d = sh_wp;
    sh_wm_d = sh_wm;
    if (ACCUM && commit_c) begin
      sh_a_d  = '0;
      sh_b_d  = '0;
      sh_bs_d = '0;
      sh_wp_d = '0;
      sh_wm_d = '0;
    end
    if (lcd_strobe) begin
      if (cpu_id == SM5A_ID) begin
        sh_wp_d = cpu_w_prime | (ACCUM ? sh_wp_d : '0);
        sh_wm_d = cpu_w_main  | (ACCUM ? sh_wm_d : '0);
      end else begin
        for (int n = 0; n < ROWS; n++) begin
          if (lcd_h[n]) begin
            sh_a_d[n] = lcd_a | (ACCUM ? sh_a_d[n] : 16'h0000);
            sh_b_d[n] = lcd_b | (ACCUM ? sh_b_d[n] : 16'h0000);
          end
        end
        for (int n = 0; n < BS_ROWS; n++) begin
          if (lcd_h[n]) sh_bs_d[n] = lcd_bs | (ACCUM ? sh_bs_d[n] : 1'b0);
        end
      end
    end
  end

  // Watchdog: a strobe in the commit cycle belongs to the next frame
  always_comb begin
    strobe_seen_d = commit_c ? lcd_strobe : (strobe_seen | lcd_strobe);
    stale_cnt_d   = stale_cnt;
    if (commit_c) begin
      if (strobe_seen)                 stale_cnt_d = '0;
      else if (stale_cnt != STALE_CNT) stale_cnt_d = stale_cnt + CNT_W'(1);
    end
  end

  assign stale_next_c = (stale_cnt_d == STALE_CNT);
  assign blank_c      = lcd_off | stale_next_c;

  // Shadow, watchdog and vblank history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q    <= 1'b0;
      sh_a        <= '0;
      sh_b        <= '0;
      sh_bs       <= '0;
      sh_wp       <= '0;
      sh_wm       <= '0;
      strobe_seen <= 1'b0;
      stale_cnt   <= '0;
    end else begin
      vblank_q    <= vblank_int;
      sh_a        <= sh_a_d;
      sh_b        <= sh_b_d;
      sh_bs       <= sh_bs_d;
      sh_wp       <= sh_wp_d;
      sh_wm       <= sh_wm_d;
      strobe_seen <= strobe_seen_d;
      stale_cnt   <= stale_cnt_d;
    end
  end

  // Committed caches and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_segment_a  <= '0;
      cache_segment_b  <= '0;
      cache_segment_bs <= '0;
      cache_w_prime    <= '0;
      cache_w_main     <= '0;
      commit_pulse     <= 1'b0;
      display_stale    <= 1'b0;
    end else begin
      commit_pulse  <= (state_d == ST_COMMIT);
      display_stale <= stale_next_c;
      if (commit_c) begin
        cache_segment_a  <= blank_c ? '0 : sh_a;
        cache_segment_b  <= blank_c ? '0 : sh_b;
        cache_segment_bs <= blank_c ? '0 : sh_bs;
        cache_w_prime    <= blank_c ? '0 : sh_wp;
        cache_w_main     <= blank_c ? '0 : sh_wm;
      end
    end
  end

endmodule
